// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data memory port among NUM_REQ_P cores.
// A grant is held from REQ until the transaction completes, is withdrawn, or the watchdog fires.
package dmem_arbiter_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ_P = 2,
    parameter int TIMEOUT_P = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  mem_in_s              core_mem_i  [NUM_REQ_P],
    input  logic [31:0]          core_addr_i [NUM_REQ_P],
    output mem_out_s             core_mem_o  [NUM_REQ_P],
    output mem_in_s              mem_o,
    output logic [31:0]          mem_addr_o,
    input  mem_out_s             mem_i,
    output logic [NUM_REQ_P-1:0] grant_o,
    output logic                 timeout_o,
    output logic [1:0]           state_o
);
    // Handshake: a core's request is live while core_mem_i.valid is high; memory accepts
    // it with mem_i.yumi, returns data with mem_i.valid, and the core consumes it with yumi.

    localparam int IW = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;
    localparam int CW = $clog2(TIMEOUT_P + 1);

    state_e          state;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   last_grant;
    logic [CW-1:0]   wd_cnt;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand_idx;
    logic            active;
    mem_in_s         gnt_req;
    logic            done;

    // Search starts one past the last completed owner so every core gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_REQ_P; i++) begin
            cand_idx = IW'((int'(last_grant) + i) % NUM_REQ_P);
            if (!pick_found && core_mem_i[cand_idx].valid) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign active  = (state != ST_IDLE);
    assign gnt_req = core_mem_i[grant_idx];
    assign done    = mem_i.valid && gnt_req.yumi;
    assign state_o = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            grant_o    <= '0;
            last_grant <= IW'(NUM_REQ_P - 1);
            wd_cnt     <= '0;
            timeout_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state     <= ST_REQ;
                        grant_idx <= pick_idx;
                        grant_o   <= {{(NUM_REQ_P-1){1'b0}}, 1'b1} << pick_idx;
                    end
                end
                ST_REQ: begin
                    if (!gnt_req.valid) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                    end else if (mem_i.yumi) begin
                        if (done) begin
                            state      <= ST_IDLE;
                            grant_o    <= '0;
                            last_grant <= grant_idx;
                        end else begin
                            state  <= ST_RESP;
                            wd_cnt <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    if (wd_cnt != CW'(TIMEOUT_P)) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                    if (done) begin
                        state      <= ST_IDLE;
                        grant_o    <= '0;
                        last_grant <= grant_idx;
                    end else if (wd_cnt >= CW'(TIMEOUT_P - 1)) begin
                        // This RESP cycle is the TIMEOUT_P-th one: give up on the memory.
                        state      <= ST_IDLE;
                        grant_o    <= '0;
                        last_grant <= grant_idx;
                        timeout_o  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_o      = '0;
        mem_addr_o = '0;
        if (active) begin
            mem_o      = gnt_req;
            mem_addr_o = core_addr_i[grant_idx];
        end
        for (int k = 0; k < NUM_REQ_P; k++) begin
            core_mem_o[k].read_data = mem_i.read_data;
            core_mem_o[k].valid     = active && (grant_idx == IW'(k)) && mem_i.valid;
            core_mem_o[k].yumi      = active && (grant_idx == IW'(k)) && mem_i.yumi;
        end
    end
endmodule
